// File: rtl/sub_pkg.sv
// Shared constants for the digit-serial subtractor: FSM encodings and
// helpers deriving digit count and counter width from the parameters.
package sub_pkg;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_RUN  = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    function automatic int ndig_f(input int dw, input int gw);
        return dw / gw;
    endfunction

    // Counter must be at least one bit even for a single-digit configuration.
    function automatic int cnt_w_f(input int n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/sub_digit.sv
// One digit of ripple subtraction: {bout, d} = a_d - b_d - bin on
// DIGITWIDTH+1 zero-extended bits.
module sub_digit #(
    parameter int DIGITWIDTH = 2
) (
    input  logic [DIGITWIDTH-1:0] a_d,
    input  logic [DIGITWIDTH-1:0] b_d,
    input  logic                  bin,
    output logic [DIGITWIDTH-1:0] d,
    output logic                  bout
);

    logic [DIGITWIDTH:0] w_full;

    always_comb begin
        w_full = {1'b0, a_d} - {1'b0, b_d} - {{DIGITWIDTH{1'b0}}, bin};
        d      = w_full[DIGITWIDTH-1:0];
        bout   = w_full[DIGITWIDTH];
    end

endmodule

// File: rtl/sub_serial.sv
// Digit-serial subtractor: diff = a - b over DATAWIDTH/DIGITWIDTH cycles with
// start/busy/done handshake, signed/unsigned overflow and optional saturation.
module sub_serial
    import sub_pkg::*;
#(
    parameter int DATAWIDTH  = 8,
    parameter int DIGITWIDTH = 2
) (
    input  logic                 Clk,
    input  logic                 Rst,
    input  logic                 start,
    input  logic [DATAWIDTH-1:0] a,
    input  logic [DATAWIDTH-1:0] b,
    input  logic                 sgn,
    input  logic                 sat,
    output logic                 busy,
    output logic                 done,
    output logic [DATAWIDTH-1:0] diff,
    output logic                 borrow,
    output logic                 ovf
);

    localparam int NDIG = ndig_f(DATAWIDTH, DIGITWIDTH);
    localparam int CW   = cnt_w_f(NDIG);
    localparam logic [CW-1:0] LAST = CW'(NDIG - 1);

    logic [1:0]           r_state;
    logic [DATAWIDTH-1:0] r_a;
    logic [DATAWIDTH-1:0] r_b;
    logic [DATAWIDTH-1:0] r_res;
    logic [DATAWIDTH-1:0] r_diff;
    logic                 r_a_msb;
    logic                 r_b_msb;
    logic                 r_sgn;
    logic                 r_sat;
    logic                 r_bin;
    logic                 r_borrow;
    logic                 r_ovf;
    logic [CW-1:0]        r_cnt;

    logic [DIGITWIDTH-1:0] w_d;
    logic                  w_bout;
    logic [DATAWIDTH-1:0]  w_res_next;
    logic [DATAWIDTH-1:0]  w_min;
    logic [DATAWIDTH-1:0]  w_sat_val;
    logic [DATAWIDTH-1:0]  w_final;
    logic                  w_ovf;

    sub_digit #(.DIGITWIDTH(DIGITWIDTH)) u_digit (
        .a_d  (r_a[DIGITWIDTH-1:0]),
        .b_d  (r_b[DIGITWIDTH-1:0]),
        .bin  (r_bin),
        .d    (w_d),
        .bout (w_bout)
    );

    // Shift-based result assembly also covers DIGITWIDTH == DATAWIDTH,
    // where a part-select of the remaining bits would be empty.
    always_comb begin
        w_res_next = (r_res >> DIGITWIDTH)
                   | (DATAWIDTH'(w_d) << (DATAWIDTH - DIGITWIDTH));
        if (r_sgn)
            w_ovf = (r_a_msb != r_b_msb) && (w_res_next[DATAWIDTH-1] != r_a_msb);
        else
            w_ovf = w_bout;
        w_min = DATAWIDTH'(1) << (DATAWIDTH - 1);
        if (!r_sgn)
            w_sat_val = '0;
        else if (r_a_msb)
            w_sat_val = w_min;
        else
            w_sat_val = ~w_min;
        w_final = (r_sat && w_ovf) ? w_sat_val : w_res_next;
    end

    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            r_state  <= ST_IDLE;
            r_a      <= '0;
            r_b      <= '0;
            r_res    <= '0;
            r_diff   <= '0;
            r_a_msb  <= 1'b0;
            r_b_msb  <= 1'b0;
            r_sgn    <= 1'b0;
            r_sat    <= 1'b0;
            r_bin    <= 1'b0;
            r_borrow <= 1'b0;
            r_ovf    <= 1'b0;
            r_cnt    <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (start) begin
                        r_a     <= a;
                        r_b     <= b;
                        r_a_msb <= a[DATAWIDTH-1];
                        r_b_msb <= b[DATAWIDTH-1];
                        r_sgn   <= sgn;
                        r_sat   <= sat;
                        r_bin   <= 1'b0;
                        r_cnt   <= '0;
                        r_res   <= '0;
                        r_state <= ST_RUN;
                    end
                end
                ST_RUN: begin
                    r_a   <= r_a >> DIGITWIDTH;
                    r_b   <= r_b >> DIGITWIDTH;
                    r_bin <= w_bout;
                    r_res <= w_res_next;
                    r_cnt <= r_cnt + 1'b1;
                    if (r_cnt == LAST) begin
                        r_diff   <= w_final;
                        r_borrow <= w_bout;
                        r_ovf    <= w_ovf;
                        r_state  <= ST_DONE;
                    end
                end
                ST_DONE: r_state <= ST_IDLE;
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign busy   = (r_state == ST_RUN);
    assign done   = (r_state == ST_DONE);
    assign diff   = r_diff;
    assign borrow = r_borrow;
    assign ovf    = r_ovf;

endmodule
